// File: rtl/cnn_buf_pkg.sv
// Shared constants and helpers for the CNN buffer return-path blocks.
// The default DW/LAT/DEPTH values match the issuing modules.
package cnn_buf_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_LAT   = 32;
  localparam int DEF_DEPTH = 64;

  // Width of a counter that must hold every value from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lat_return_buffer_if.sv
// Issue / return / downstream handshake bundle for lat_return_buffer.
// lat_err exists only when LAT_RETURN_BUFFER_LAT_CHECK_EN is defined.
interface lat_return_buffer_if
  import cnn_buf_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = cnt_width(DEPTH);

  logic          issue_en;
  logic          issue_ok;
  logic          ret_valid;
  logic [DW-1:0] ret_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] occupancy;
  logic          ovf_err;
  logic          unexp_err;
`ifdef LAT_RETURN_BUFFER_LAT_CHECK_EN
  logic          lat_err;
`endif

  modport master (
    output issue_en, ret_valid, ret_data, out_ready,
    input  issue_ok, out_valid, out_data, occupancy, ovf_err, unexp_err
`ifdef LAT_RETURN_BUFFER_LAT_CHECK_EN
    , input lat_err
`endif
  );

  modport slave (
    input  issue_en, ret_valid, ret_data, out_ready,
    output issue_ok, out_valid, out_data, occupancy, ovf_err, unexp_err
`ifdef LAT_RETURN_BUFFER_LAT_CHECK_EN
    , output lat_err
`endif
  );

endinterface

// File: rtl/lat_rb_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH need not be a power of two.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module lat_rb_fifo
  import cnn_buf_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == {CW{1'b0}});
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and count next-state.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/lat_return_buffer.sv
// Catches fixed-latency returns in a FIFO and grants issue credits so nothing is lost.
// Define LAT_RETURN_BUFFER_LAT_CHECK_EN to build the return-timing checker and lat_err.
module lat_return_buffer
  import cnn_buf_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int LAT   = DEF_LAT,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  lat_return_buffer_if.slave  bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam int SW = CW + 1;

  if (LAT < 2) begin : g_bad_lat
    $error("lat_return_buffer: LAT must be >= 2");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("lat_return_buffer: DEPTH must be >= 1");
  end

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] fifo_head;
  logic          pop;
  logic          push;
  logic          drop;
  logic          no_flight;
  logic          dec;
  logic [CW-1:0] occ_next;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          issue_ok_q, issue_ok_d;
  logic          ovf_err_q, ovf_err_d;
  logic          unexp_err_q, unexp_err_d;

  lat_rb_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.ret_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_head;
  assign bus.occupancy = fifo_count;
  assign bus.issue_ok  = issue_ok_q;
  assign bus.ovf_err   = ovf_err_q;
  assign bus.unexp_err = unexp_err_q;

  // Credit accounting and sticky error detection.
  always_comb begin
    pop       = bus.out_ready & ~fifo_empty;
    push      = bus.ret_valid & (~fifo_full | pop);
    drop      = bus.ret_valid & fifo_full & ~pop;
    no_flight = (inflight_q == {CW{1'b0}});
    dec       = bus.ret_valid & ~no_flight;

    inflight_d = inflight_q;
    case ({bus.issue_en, dec})
      2'b10: begin
        if (inflight_q != CW'(DEPTH)) begin
          inflight_d = inflight_q + CW'(1);
        end else begin
          inflight_d = inflight_q;
        end
      end
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    // Mirrors the FIFO count update so issue_ok can be a plain flop.
    case ({push, pop})
      2'b10:   occ_next = fifo_count + CW'(1);
      2'b01:   occ_next = fifo_count - CW'(1);
      default: occ_next = fifo_count;
    endcase

    issue_ok_d  = (({1'b0, occ_next} + {1'b0, inflight_d}) < SW'(DEPTH));
    ovf_err_d   = ovf_err_q | (bus.issue_en & ~issue_ok_q) | drop;
    unexp_err_d = unexp_err_q | (bus.ret_valid & no_flight);
  end

  // Credit and error registers; a reset forgets any request still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= {CW{1'b0}};
      issue_ok_q  <= 1'b1;
      ovf_err_q   <= 1'b0;
      unexp_err_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      issue_ok_q  <= issue_ok_d;
      ovf_err_q   <= ovf_err_d;
      unexp_err_q <= unexp_err_d;
    end
  end

`ifdef LAT_RETURN_BUFFER_LAT_CHECK_EN
  logic [LAT-1:0] lat_sr_q, lat_sr_d;
  logic           lat_err_q, lat_err_d;

  assign bus.lat_err = lat_err_q;

  // Bit LAT-1 is the issue that should be returning in the current cycle.
  always_comb begin
    lat_sr_d  = {lat_sr_q[LAT-2:0], bus.issue_en};
    lat_err_d = lat_err_q | (bus.ret_valid != lat_sr_q[LAT-1]);
  end

  // Latency-check registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_sr_q  <= {LAT{1'b0}};
      lat_err_q <= 1'b0;
    end else begin
      lat_sr_q  <= lat_sr_d;
      lat_err_q <= lat_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_lat_return_buffer.sv
// Directed bench for lat_return_buffer with DW=32, LAT=4, DEPTH=8.
module tb_lat_return_buffer;

  localparam int DW    = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  lat_return_buffer_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  lat_return_buffer #(
    .DW    (DW),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Apply inputs for one cycle, then land 1 time unit after the rising edge.
  task automatic cyc(input logic ie, input logic rv, input logic [31:0] rd, input logic ordy);
    bus.issue_en  = ie;
    bus.ret_valid = rv;
    bus.ret_data  = rd;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.issue_en  = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_data  = 32'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic  iss [0:15];
    int    nret;
    int    nacc;
    int    exp4 [8];

    n_total = 0;
    n_pass  = 0;
    do_reset();

    // Reset state
    check("rst_occ",      bus.occupancy, 64'd0);
    check("rst_valid",    bus.out_valid, 64'd0);
    check("rst_issue_ok", bus.issue_ok,  64'd1);
    check("rst_ovf",      bus.ovf_err,   64'd0);
    check("rst_unexp",    bus.unexp_err, 64'd0);

    // 1. Reset mid-operation: 3 stored, 2 in flight
    for (int t = 0; t < 7; t++) begin
      cyc((t < 5) ? 1'b1 : 1'b0, (t >= 4) ? 1'b1 : 1'b0, 32'(t), 1'b0);
    end
    check("t1_occ_before", bus.occupancy, 64'd3);
    check("t1_ok_before",  bus.issue_ok,  64'd1);
    rst = 1'b1;
    #1;
    check("t1_occ_async",   bus.occupancy, 64'd0);
    check("t1_valid_async", bus.out_valid, 64'd0);
    check("t1_ok_async",    bus.issue_ok,  64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 32'd99, 1'b0);
    check("t1_late_unexp", bus.unexp_err, 64'd1);
    check("t1_late_ovf",   bus.ovf_err,   64'd0);

    // 2. Streaming with out_ready held high
    do_reset();
    for (int t = 0; t < 25; t++) begin
      cyc((t < 20) ? 1'b1 : 1'b0, (t >= 4 && t < 24) ? 1'b1 : 1'b0, 32'(t - 4), 1'b1);
      check("t2_issue_ok", bus.issue_ok, 64'd1);
      if (t >= 4 && t < 24) begin
        check("t2_valid", bus.out_valid, 64'd1);
        check("t2_data",  bus.out_data,  64'(t - 4));
      end
    end
    check("t2_occ_end", bus.occupancy, 64'd0);
    check("t2_ovf",     bus.ovf_err,   64'd0);
    check("t2_unexp",   bus.unexp_err, 64'd0);

    // 3. Backpressure: issue whenever issue_ok, consumer stalled
    nret = 0;
    nacc = 0;
    for (int t = 0; t < 14; t++) begin
      logic ie;
      logic rv;
      ie     = bus.issue_ok;
      iss[t] = ie;
      rv     = (t >= LAT) ? iss[t - LAT] : 1'b0;
      if (ie) nacc++;
      cyc(ie, rv, 32'(100 + nret), 1'b0);
      if (rv) nret++;
    end
    check("t3_accepted", 64'(nacc),     64'd8);
    check("t3_ok_low",   bus.issue_ok,  64'd0);
    check("t3_occ_full", bus.occupancy, 64'd8);
    check("t3_head",     bus.out_data,  64'd100);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t3_occ_pop",  bus.occupancy, 64'd7);
    check("t3_ok_back",  bus.issue_ok,  64'd1);
    check("t3_head_pop", bus.out_data,  64'd101);
    check("t3_ovf",      bus.ovf_err,   64'd0);

    // 4. Full with simultaneous push and pop
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("t4_ok_spent", bus.issue_ok, 64'd0);
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 32'd200, 1'b0);
    check("t4_occ_full",   bus.occupancy, 64'd8);
    check("t4_head_stall", bus.out_data,  64'd101);
    check("t4_unexp_pre",  bus.unexp_err, 64'd0);
    cyc(1'b0, 1'b1, 32'd201, 1'b1);
    check("t4_occ_same", bus.occupancy, 64'd8);
    check("t4_head_adv", bus.out_data,  64'd102);
    check("t4_ovf",      bus.ovf_err,   64'd0);
    check("t4_unexp",    bus.unexp_err, 64'd1);
    exp4 = '{102, 103, 104, 105, 106, 107, 200, 201};
    for (int i = 0; i < 8; i++) begin
      check("t4_drain", bus.out_data, 64'(exp4[i]));
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
    end
    check("t4_occ_empty", bus.occupancy, 64'd0);
    check("t4_valid_end", bus.out_valid, 64'd0);

    // 5. Protocol errors and stickiness
    do_reset();
    cyc(1'b0, 1'b1, 32'd55, 1'b0);
    check("t5_unexp",      bus.unexp_err, 64'd1);
    check("t5_unexp_occ",  bus.occupancy, 64'd1);
    check("t5_unexp_data", bus.out_data,  64'd55);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (8) cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("t5_ok_low",   bus.issue_ok, 64'd0);
    check("t5_ovf_pre",  bus.ovf_err,  64'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    check("t5_ovf",      bus.ovf_err,  64'd1);
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    check("t5_ovf_hold",   bus.ovf_err,   64'd1);
    check("t5_unexp_hold", bus.unexp_err, 64'd1);
    do_reset();
    check("t5_ovf_clr",   bus.ovf_err,   64'd0);
    check("t5_unexp_clr", bus.unexp_err, 64'd0);

`ifdef LAT_RETURN_BUFFER_LAT_CHECK_EN
    // 6. Return one cycle late
    check("t6_lat_rst", bus.lat_err, 64'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    check("t6_lat_early", bus.lat_err, 64'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    check("t6_lat_set", bus.lat_err, 64'd1);
    cyc(1'b0, 1'b1, 32'd77, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    check("t6_lat_hold", bus.lat_err, 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
